// File: rtl/wishbone_slave_param_if.sv
// Wishbone classic bus bundle between a master and the SD host slave.
// Only the bus handshake and data travel here; clock and reset stay plain ports.
interface wishbone_slave_param_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADR_WIDTH  = 5
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADR_WIDTH-1:0]  adr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic                  ack_o;
    logic                  err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, wb_data_i,
        output wb_data_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, wb_data_i,
        input  wb_data_o, ack_o, err_o
    );
endinterface

// File: rtl/wishbone_slave_param.sv
// Wishbone classic slave in front of the SD host core.
// Decodes a register window plus CMD / FIFO_WR / FIFO_RD / DATA control addresses,
// issues one-cycle host strobes and finishes every transfer with exactly one ack or err.
// CMD and DATA writes hold the bus in WAIT until the matching done input, a timeout,
// or the master dropping cyc_i.
module wishbone_slave_param #(
    parameter int DATA_WIDTH = 128,
    parameter int ADR_WIDTH  = 5,
    parameter int NUM_REGS   = 16,
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    wishbone_slave_param_if.slave wb,
    input  logic [DATA_WIDTH-1:0] host_data_i,
    input  logic                  cmd_done_i,
    input  logic                  data_done_i,
    output logic [DATA_WIDTH-1:0] host_data_o,
    output logic [ADR_WIDTH-1:0]  reg_adr_o,
    output logic                  new_command,
    output logic                  new_data,
    output logic                  reg_read_en,
    output logic                  reg_write_en,
    output logic                  fifo_read_en,
    output logic                  fifo_write_en
);

    // Control addresses sit directly above the register window.
    localparam logic [ADR_WIDTH-1:0] A_CMD     = ADR_WIDTH'(NUM_REGS);
    localparam logic [ADR_WIDTH-1:0] A_FIFO_WR = ADR_WIDTH'(NUM_REGS + 1);
    localparam logic [ADR_WIDTH-1:0] A_FIFO_RD = ADR_WIDTH'(NUM_REGS + 2);
    localparam logic [ADR_WIDTH-1:0] A_DATA    = ADR_WIDTH'(NUM_REGS + 3);
    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WAIT
    } state_t;

    state_t                state_q, state_d;
    logic                  err_flag_q, err_flag_d;
    logic                  wait_data_q, wait_data_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] hout_q, hout_d;
    logic [ADR_WIDTH-1:0]  radr_q, radr_d;
    logic                  cmd_q, cmd_d;
    logic                  dat_q, dat_d;
    logic                  rrd_q, rrd_d;
    logic                  rwr_q, rwr_d;
    logic                  frd_q, frd_d;
    logic                  fwr_q, fwr_d;

    logic                  request;
    logic                  is_reg;
    logic                  done_sel;
    logic [TIMEOUT_W-1:0]  cnt_inc;

    assign request  = wb.cyc_i & wb.stb_i;
    assign is_reg   = (wb.adr_i < A_CMD);
    assign done_sel = wait_data_q ? data_done_i : cmd_done_i;
    assign cnt_inc  = cnt_q + TIMEOUT_W'(1);

    // Next-state and next-output decode; every output is registered so strobes and
    // ack/err are clean single-cycle pulses aligned to the clock.
    always_comb begin
        state_d     = state_q;
        err_flag_d  = err_flag_q;
        wait_data_d = wait_data_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        hout_d      = hout_q;
        radr_d      = radr_q;
        cmd_d       = 1'b0;
        dat_d       = 1'b0;
        rrd_d       = 1'b0;
        rwr_d       = 1'b0;
        frd_d       = 1'b0;
        fwr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    err_flag_d = 1'b0;
                    cnt_d      = '0;
                    if (is_reg) begin
                        radr_d  = wb.adr_i;
                        state_d = RESP;
                        if (wb.we_i) begin
                            rwr_d  = 1'b1;
                            hout_d = wb.wb_data_i;
                        end else begin
                            rrd_d = 1'b1;
                        end
                    end else if (wb.adr_i == A_FIFO_WR && wb.we_i) begin
                        fwr_d   = 1'b1;
                        hout_d  = wb.wb_data_i;
                        state_d = RESP;
                    end else if (wb.adr_i == A_FIFO_RD && !wb.we_i) begin
                        frd_d   = 1'b1;
                        state_d = RESP;
                    end else if (wb.adr_i == A_CMD && wb.we_i) begin
                        cmd_d       = 1'b1;
                        hout_d      = wb.wb_data_i;
                        wait_data_d = 1'b0;
                        state_d     = WAIT;
                    end else if (wb.adr_i == A_DATA && wb.we_i) begin
                        dat_d       = 1'b1;
                        wait_data_d = 1'b1;
                        state_d     = WAIT;
                    end else begin
                        err_flag_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end

            RESP: begin
                // Host read data is valid while the read strobe is high, i.e. now.
                if (rrd_q || frd_q) begin
                    rdata_d = host_data_i;
                end
                ack_d   = !err_flag_q;
                err_d   = err_flag_q;
                state_d = IDLE;
            end

            WAIT: begin
                // Abort beats done, and done beats timeout.
                cnt_d = cnt_inc;
                if (!wb.cyc_i) begin
                    state_d = IDLE;
                end else if (done_sel) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && cnt_inc == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            err_flag_q  <= 1'b0;
            wait_data_q <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            hout_q      <= '0;
            radr_q      <= '0;
            cmd_q       <= 1'b0;
            dat_q       <= 1'b0;
            rrd_q       <= 1'b0;
            rwr_q       <= 1'b0;
            frd_q       <= 1'b0;
            fwr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_flag_q  <= err_flag_d;
            wait_data_q <= wait_data_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            hout_q      <= hout_d;
            radr_q      <= radr_d;
            cmd_q       <= cmd_d;
            dat_q       <= dat_d;
            rrd_q       <= rrd_d;
            rwr_q       <= rwr_d;
            frd_q       <= frd_d;
            fwr_q       <= fwr_d;
        end
    end

    assign wb.ack_o      = ack_q;
    assign wb.err_o      = err_q;
    assign wb.wb_data_o  = rdata_q;
    assign host_data_o   = hout_q;
    assign reg_adr_o     = radr_q;
    assign new_command   = cmd_q;
    assign new_data      = dat_q;
    assign reg_read_en   = rrd_q;
    assign reg_write_en  = rwr_q;
    assign fifo_read_en  = frd_q;
    assign fifo_write_en = fwr_q;

endmodule

// File: tb/tb_wishbone_slave_param.sv
// Bench for wishbone_slave_param: two instances (16-register window with an 8-cycle
// timeout, and an 8-register window with the timeout disabled). A driver issues
// transfers and queues the expected strobe and response events; per-instance monitors
// pop and compare whenever a strobe, ack or err shows up.
module tb_wishbone_slave_param;

    localparam int DW      = 128;
    localparam int AW      = 5;
    localparam int NREGS_A = 16;
    localparam int TMO_A   = 8;
    localparam int NREGS_B = 8;
    localparam int TMO_B   = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [DW-1:0] rdata;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [5:0]  mask;
        logic [AW-1:0] radr;
        logic [DW-1:0] hout;
    } strb_t;

    typedef struct {
        logic [DW-1:0] last_rd;
        logic [DW-1:0] hout;
        logic [AW-1:0] radr;
    } mdl_t;

    logic clock = 1'b0;
    logic reset;
    int   cycle   = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   started = 1'b0;

    resp_t rq_a[$], rq_b[$];
    strb_t sq_a[$], sq_b[$];
    mdl_t  m_a, m_b;

    wishbone_slave_param_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus_a();
    wishbone_slave_param_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus_b();

    logic [DW-1:0] hdi_a, hdi_b, hout_a, hout_b;
    logic [AW-1:0] radr_a, radr_b;
    logic cd_a, dd_a, cd_b, dd_b;
    logic nc_a, nd_a, rr_a, rw_a, fr_a, fw_a;
    logic nc_b, nd_b, rr_b, rw_b, fr_b, fw_b;

    wishbone_slave_param #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .NUM_REGS(NREGS_A), .TIMEOUT_W(16), .TIMEOUT(TMO_A)
    ) dut_a (
        .clock(clock), .reset(reset), .wb(bus_a),
        .host_data_i(hdi_a), .cmd_done_i(cd_a), .data_done_i(dd_a),
        .host_data_o(hout_a), .reg_adr_o(radr_a),
        .new_command(nc_a), .new_data(nd_a),
        .reg_read_en(rr_a), .reg_write_en(rw_a),
        .fifo_read_en(fr_a), .fifo_write_en(fw_a)
    );

    wishbone_slave_param #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .NUM_REGS(NREGS_B), .TIMEOUT_W(16), .TIMEOUT(TMO_B)
    ) dut_b (
        .clock(clock), .reset(reset), .wb(bus_b),
        .host_data_i(hdi_b), .cmd_done_i(cd_b), .data_done_i(dd_b),
        .host_data_o(hout_b), .reg_adr_o(radr_b),
        .new_command(nc_b), .new_data(nd_b),
        .reg_read_en(rr_b), .reg_write_en(rw_b),
        .fifo_read_en(fr_b), .fifo_write_en(fw_b)
    );

    // Free-running clock and a cycle index counting rising edges.
    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Hard stop in case something stalls the driver.
    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Address map from the slave's rules: 0 reg rd, 1 reg wr, 2 fifo rd, 3 fifo wr,
    // 4 cmd, 5 data, 6 illegal. Kinds 0..5 double as the strobe bit index.
    function automatic int classify(input logic [AW-1:0] adr, input logic we, input int n);
        int a;
        a = int'(adr);
        if (a < n) return we ? 1 : 0;
        if (a == n && we) return 4;
        if (a == n + 1 && we) return 3;
        if (a == n + 2 && !we) return 2;
        if (a == n + 3 && we) return 5;
        return 6;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic drive_bus(input int which, input logic cyc, input logic stb, input logic we,
                             input logic [AW-1:0] adr, input logic [DW-1:0] d);
        if (which == 0) begin
            bus_a.cyc_i = cyc; bus_a.stb_i = stb; bus_a.we_i = we;
            bus_a.adr_i = adr; bus_a.wb_data_i = d;
        end else begin
            bus_b.cyc_i = cyc; bus_b.stb_i = stb; bus_b.we_i = we;
            bus_b.adr_i = adr; bus_b.wb_data_i = d;
        end
    endtask

    task automatic drive_host(input int which, input logic [DW-1:0] hd, input logic cd, input logic dd);
        if (which == 0) begin
            hdi_a = hd; cd_a = cd; dd_a = dd;
        end else begin
            hdi_b = hd; cd_b = cd; dd_b = dd;
        end
    endtask

    task automatic push_strb(input int which, input strb_t s);
        if (which == 0) sq_a.push_back(s); else sq_b.push_back(s);
    endtask

    task automatic push_resp(input int which, input resp_t r);
        if (which == 0) rq_a.push_back(r); else rq_b.push_back(r);
    endtask

    // One transfer, called at a falling edge. Expectations are queued before the
    // request edge; the task returns at the falling edge of the response cycle.
    // done_dly: cycles after the request edge at which the selected done is sampled
    // (0 = never). keep leaves cyc/stb asserted for a back-to-back follow-up.
    task automatic apply_stimulus(input int which, input logic we, input logic [AW-1:0] adr,
                                  input logic [DW-1:0] wdata, input logic [DW-1:0] hdata,
                                  input int done_dly, input bit keep);
        int    n, tmo, kind, c0, fin;
        bit    waits;
        logic  sel;
        mdl_t  m;
        resp_t r;
        strb_t s;
        n    = (which == 0) ? NREGS_A : NREGS_B;
        tmo  = (which == 0) ? TMO_A : TMO_B;
        m    = (which == 0) ? m_a : m_b;
        kind = classify(adr, we, n);
        c0   = cycle + 1;
        waits = (kind == 4 || kind == 5);
        if (kind < 6) begin
            if (kind == 0 || kind == 1) m.radr = adr;
            if (kind == 1 || kind == 3 || kind == 4) m.hout = wdata;
            if (kind == 0 || kind == 2) m.last_rd = hdata;
            s.cyc  = c0;
            s.mask = 6'b1 << kind;
            s.radr = m.radr;
            s.hout = m.hout;
            push_strb(which, s);
        end
        r.err = (kind == 6);
        r.cyc = c0 + 1;
        if (waits) begin
            if (tmo != 0 && (done_dly == 0 || done_dly > tmo)) begin
                r.err = 1'b1;
                r.cyc = c0 + tmo;
            end else begin
                r.err = 1'b0;
                r.cyc = c0 + done_dly;
            end
        end
        r.rdata = m.last_rd;
        push_resp(which, r);
        if (which == 0) m_a = m; else m_b = m;

        drive_host(which, hdata, 1'b0, 1'b0);
        drive_bus(which, 1'b1, 1'b1, we, adr, wdata);
        fin = r.cyc;
        while (cycle < fin) begin
            if (waits) begin
                // The other done input is held high throughout and must be ignored.
                sel = (cycle + 1 == c0 + done_dly);
                if (kind == 4) drive_host(which, hdata, sel, 1'b1);
                else           drive_host(which, hdata, 1'b1, sel);
            end
            @(negedge clock);
        end
        drive_host(which, hdata, 1'b0, 1'b0);
        if (!keep) drive_bus(which, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // CMD write, then drop cyc_i in WAIT while cmd_done_i is high: no ack/err allowed.
    task automatic abort_in_wait(input int which, input logic [DW-1:0] wdata);
        int    c0, n;
        strb_t s;
        n  = (which == 0) ? NREGS_A : NREGS_B;
        c0 = cycle + 1;
        if (which == 0) m_a.hout = wdata; else m_b.hout = wdata;
        s.cyc  = c0;
        s.mask = 6'b010000;
        s.radr = (which == 0) ? m_a.radr : m_b.radr;
        s.hout = wdata;
        push_strb(which, s);
        drive_host(which, '0, 1'b0, 1'b0);
        drive_bus(which, 1'b1, 1'b1, 1'b1, AW'(n), wdata);
        while (cycle < c0 + 2) @(negedge clock);
        drive_bus(which, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_host(which, '0, 1'b1, 1'b0);
        @(negedge clock);
        drive_host(which, '0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] wbo, input logic ack,
                                input logic err, input logic [DW-1:0] hout,
                                input logic [AW-1:0] radr, input logic [5:0] mask);
        check({tag, "_wb_data_o"}, wbo, '0);
        check({tag, "_ack_o"}, DW'(ack), '0);
        check({tag, "_err_o"}, DW'(err), '0);
        check({tag, "_host_data_o"}, hout, '0);
        check({tag, "_reg_adr_o"}, DW'(radr), '0);
        check({tag, "_strobes"}, DW'(mask), '0);
    endtask

    // Reset asserted while dut_a waits on a CMD completion, done high meanwhile.
    task automatic reset_in_wait(input logic [DW-1:0] wdata);
        int    c0;
        strb_t s;
        c0 = cycle + 1;
        m_a.hout = wdata;
        s.cyc  = c0;
        s.mask = 6'b010000;
        s.radr = m_a.radr;
        s.hout = wdata;
        push_strb(0, s);
        drive_host(0, '0, 1'b0, 1'b0);
        drive_bus(0, 1'b1, 1'b1, 1'b1, AW'(NREGS_A), wdata);
        while (cycle < c0 + 2) @(negedge clock);
        reset = 1'b1;
        drive_bus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_host(0, '0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        check_output("rst_wait_a", bus_a.wb_data_o, bus_a.ack_o, bus_a.err_o, hout_a, radr_a,
                     {nd_a, nc_a, fw_a, fr_a, rw_a, rr_a});
        m_a = '{default: '0};
        m_b = '{default: '0};
        drive_host(0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Monitor body: pops the next expected strobe / response for one instance.
    task automatic mon_dut(input int which, input logic ack, input logic err,
                           input logic [DW-1:0] wbo, input logic [5:0] mask,
                           input logic [AW-1:0] radr, input logic [DW-1:0] hout);
        resp_t r;
        strb_t s;
        bit    empty;
        string p;
        p = (which == 0) ? "a" : "b";
        if (mask != 6'b0) begin
            empty = (which == 0) ? (sq_a.size() == 0) : (sq_b.size() == 0);
            if (empty) begin
                check({p, "_strobe_unexpected"}, DW'(mask), '0);
            end else begin
                if (which == 0) s = sq_a.pop_front(); else s = sq_b.pop_front();
                check({p, "_strobe_cycle"}, DW'(cycle), DW'(s.cyc));
                check({p, "_strobe_kind"}, DW'(mask), DW'(s.mask));
                check({p, "_reg_adr_o"}, DW'(radr), DW'(s.radr));
                check({p, "_host_data_o"}, hout, s.hout);
            end
        end
        if (ack || err) begin
            empty = (which == 0) ? (rq_a.size() == 0) : (rq_b.size() == 0);
            if (empty) begin
                check({p, "_resp_unexpected"}, DW'({ack, err}), '0);
            end else begin
                if (which == 0) r = rq_a.pop_front(); else r = rq_b.pop_front();
                check({p, "_resp_cycle"}, DW'(cycle), DW'(r.cyc));
                check({p, "_ack_o"}, DW'(ack), DW'(!r.err));
                check({p, "_err_o"}, DW'(err), DW'(r.err));
                check({p, "_wb_data_o"}, wbo, r.rdata);
            end
        end
    endtask

    // Monitors sample on the falling edge, half a cycle away from the DUT's edge.
    always @(negedge clock) begin
        if (started && !reset) begin
            mon_dut(0, bus_a.ack_o, bus_a.err_o, bus_a.wb_data_o,
                    {nd_a, nc_a, fw_a, fr_a, rw_a, rr_a}, radr_a, hout_a);
            mon_dut(1, bus_b.ack_o, bus_b.err_o, bus_b.wb_data_o,
                    {nd_b, nc_b, fw_b, fr_b, rw_b, rr_b}, radr_b, hout_b);
        end
    end

    initial begin
        int   dly;
        logic we;
        reset = 1'b1;
        m_a = '{default: '0};
        m_b = '{default: '0};
        drive_bus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_bus(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_host(0, '0, 1'b0, 1'b0);
        drive_host(1, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check_output("reset_a", bus_a.wb_data_o, bus_a.ack_o, bus_a.err_o, hout_a, radr_a,
                     {nd_a, nc_a, fw_a, fr_a, rw_a, rr_a});
        check_output("reset_b", bus_b.wb_data_o, bus_b.ack_o, bus_b.err_o, hout_b, radr_b,
                     {nd_b, nc_b, fw_b, fr_b, rw_b, rr_b});
        reset   = 1'b0;
        started = 1'b1;
        @(negedge clock);

        $display("[TB] directed transfers on the 16-register instance");
        apply_stimulus(0, 1'b1, 5'd3, 128'hA5, rand128(), 0, 1'b0);
        apply_stimulus(0, 1'b0, 5'd3, rand128(), 128'h5A, 0, 1'b0);
        apply_stimulus(0, 1'b1, 5'd16, 128'h1234, rand128(), 7, 1'b0);
        apply_stimulus(0, 1'b1, 5'd19, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(0, 1'b1, 5'd19, rand128(), rand128(), 8, 1'b0);
        apply_stimulus(0, 1'b0, 5'd16, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(0, 1'b1, 5'd18, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(0, 1'b0, 5'd25, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(0, 1'b1, 5'd25, rand128(), rand128(), 0, 1'b0);

        // stb_i without cyc_i must produce nothing.
        drive_bus(0, 1'b0, 1'b1, 1'b1, 5'd3, rand128());
        repeat (3) @(negedge clock);
        drive_bus(0, 1'b0, 1'b0, 1'b0, '0, '0);

        abort_in_wait(0, rand128());
        apply_stimulus(0, 1'b1, 5'd17, rand128(), rand128(), 0, 1'b0);
        reset_in_wait(rand128());
        apply_stimulus(0, 1'b0, 5'd18, rand128(), rand128(), 0, 1'b0);

        $display("[TB] directed transfers on the 8-register instance");
        apply_stimulus(1, 1'b1, 5'd8, rand128(), rand128(), 3, 1'b0);
        apply_stimulus(1, 1'b0, 5'd10, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(1, 1'b1, 5'd10, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(1, 1'b0, 5'd16, rand128(), rand128(), 0, 1'b0);
        apply_stimulus(1, 1'b0, 5'd7, rand128(), rand128(), 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 1'b1, 5'd9, rand128(), rand128(), 0, (i < 3));
        end

        $display("[TB] random transfers");
        for (int i = 0; i < 40; i++) begin
            dly = $urandom_range(0, 10);
            we  = 1'($urandom_range(0, 1));
            apply_stimulus(0, we, AW'($urandom_range(0, 31)), rand128(), rand128(), dly,
                           bit'($urandom_range(0, 1)));
        end
        drive_bus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 25; i++) begin
            dly = $urandom_range(1, 6);
            we  = 1'($urandom_range(0, 1));
            apply_stimulus(1, we, AW'($urandom_range(0, 15)), rand128(), rand128(), dly,
                           bit'($urandom_range(0, 1)));
        end
        drive_bus(1, 1'b0, 1'b0, 1'b0, '0, '0);

        repeat (5) @(negedge clock);
        check("a_strobes_outstanding", DW'(sq_a.size()), '0);
        check("a_resps_outstanding", DW'(rq_a.size()), '0);
        check("b_strobes_outstanding", DW'(sq_b.size()), '0);
        check("b_resps_outstanding", DW'(rq_b.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
